// File: rtl/i2c_bit_tap_if.sv
// ---------------------------------------------------------------------------
// i2c_bit_tap_if
// Bundles the tap-command handshake, the sampled bus lines, the open-drain
// pad controls and the per-bit status outputs of i2c_bit_tap.
//   master : command source / bus environment (drives cmd_vld, cmd, scl_i, sda_i)
//   slave  : the bit tap itself (drives cmd_ready, pad controls, status)
// Signals:
//   cmd_vld, cmd[2:0], cmd_ready   - command handshake
//   scl_i, sda_i                   - sampled line levels
//   scl_o, scl_t, sda_o, sda_t     - pad controls (_t=1 releases the line)
//   rd_bit, rd_bit_vld, arb_lost   - bit sample result and pulses
//   busy                           - command in progress
// ---------------------------------------------------------------------------
interface i2c_bit_tap_if;
  logic       cmd_vld;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       scl_t;
  logic       sda_o;
  logic       sda_t;
  logic       rd_bit;
  logic       rd_bit_vld;
  logic       arb_lost;
  logic       busy;

  modport master (
    output cmd_vld, cmd, scl_i, sda_i,
    input  cmd_ready, scl_o, scl_t, sda_o, sda_t, rd_bit, rd_bit_vld,
           arb_lost, busy
  );

  modport slave (
    input  cmd_vld, cmd, scl_i, sda_i,
    output cmd_ready, scl_o, scl_t, sda_o, sda_t, rd_bit, rd_bit_vld,
           arb_lost, busy
  );
endinterface

// File: rtl/i2c_bit_tap.sv
// ---------------------------------------------------------------------------
// i2c_bit_tap
// Bit-level I2C engine. Each accepted tap command (START, STOP, RSTART,
// WBIT0, WBIT1, RBIT) is played out as four quarter-bit phases of PERSCALER
// clocks on the open-drain SCL/SDA pad controls. Phases in which SCL is
// released stall while a slave holds SCL low (clock stretching). Bit
// commands sample SDA at the end of the third phase and report the value in
// a one-cycle DONE state; a WBIT1 that reads back 0 flags lost arbitration.
// NOP and the reserved code pass through DONE without touching the lines.
// Ports:
//   clock  - system clock, rising edge
//   rst    - synchronous, active-high reset
//   bus    - i2c_bit_tap_if.slave (command handshake, lines, status)
// Parameter:
//   PERSCALER - clocks per quarter-bit phase (2..65535)
// ---------------------------------------------------------------------------
module i2c_bit_tap #(
  parameter int unsigned PERSCALER = 100
) (
  input  logic           clock,
  input  logic           rst,
  i2c_bit_tap_if.slave   bus
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [15:0] CNT_LAST = 16'(PERSCALER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_STRT = 3'd1,
    CMD_STOP = 3'd2,
    CMD_WB0  = 3'd3,
    CMD_WB1  = 3'd4,
    CMD_RBIT = 3'd5,
    CMD_RSTR = 3'd6,
    CMD_RSVD = 3'd7
  } cmd_e;

  state_e           state_q;
  cmd_e             cmd_q;
  logic [1:0]       phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic             scl_t_q;
  logic             sda_t_q;
  logic             sample_q;
  logic             rd_bit_q;
  logic             rd_bit_vld_q;
  logic             arb_lost_q;
  logic             busy_q;
  logic             cmd_ready_q;

  cmd_e             cmd_in;
  logic             accept;
  logic             zero_len;
  logic             stall;
  logic             is_bit_cmd;
  logic [1:0]       p0_lines_d;
  logic [1:0]       next_lines_d;

  // Line levels {scl_t, sda_t} for a command in a given phase (1 = released).
  function automatic logic [1:0] phase_lines(cmd_e c, logic [1:0] p);
    logic [1:0] l;
    l = 2'b11;
    case (c)
      CMD_STRT: begin
        case (p)
          2'd0, 2'd1: l = 2'b11;
          2'd2:       l = 2'b10;
          default:    l = 2'b00;
        endcase
      end
      CMD_STOP: begin
        case (p)
          2'd0:       l = 2'b00;
          2'd1, 2'd2: l = 2'b10;
          default:    l = 2'b11;
        endcase
      end
      CMD_RSTR: begin
        case (p)
          2'd0:    l = 2'b01;
          2'd1:    l = 2'b11;
          2'd2:    l = 2'b10;
          default: l = 2'b00;
        endcase
      end
      CMD_WB0:           l = {(p == 2'd1) || (p == 2'd2), 1'b0};
      CMD_WB1, CMD_RBIT: l = {(p == 2'd1) || (p == 2'd2), 1'b1};
      default:           l = 2'b11;
    endcase
    return l;
  endfunction

  // Handshake decode, stretch detect and next phase line values.
  always_comb begin
    cmd_in       = cmd_e'(bus.cmd);
    accept       = bus.cmd_vld && cmd_ready_q;
    zero_len     = (cmd_in == CMD_NOP) || (cmd_in == CMD_RSVD);
    // A released SCL that still reads low is being held by a slave.
    stall        = scl_t_q && !bus.scl_i;
    is_bit_cmd   = (cmd_q == CMD_WB0) || (cmd_q == CMD_WB1) ||
                   (cmd_q == CMD_RBIT);
    p0_lines_d   = phase_lines(cmd_in, 2'd0);
    next_lines_d = phase_lines(cmd_q, 2'(phase_q + 2'd1));
  end

  // Command FSM, phase counter and all registered outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= CMD_NOP;
      phase_q      <= 2'd0;
      cnt_q        <= '0;
      scl_t_q      <= 1'b1;
      sda_t_q      <= 1'b1;
      sample_q     <= 1'b0;
      rd_bit_q     <= 1'b0;
      rd_bit_vld_q <= 1'b0;
      arb_lost_q   <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      rd_bit_vld_q <= 1'b0;
      arb_lost_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_q       <= cmd_in;
            phase_q     <= 2'd0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            if (zero_len) begin
              state_q <= DONE;
            end else begin
              // P0 levels appear on the cycle right after acceptance.
              state_q            <= EXEC;
              {scl_t_q, sda_t_q} <= p0_lines_d;
            end
          end
        end

        EXEC: begin
          if (!stall) begin
            if (cnt_q != CNT_LAST) begin
              cnt_q <= cnt_q + 16'd1;
            end else begin
              cnt_q <= '0;
              if (phase_q == 2'd2) begin
                sample_q <= bus.sda_i;
              end
              if (phase_q == 2'd3) begin
                // Lines keep their P3 levels until the next command.
                state_q <= DONE;
                if (is_bit_cmd) begin
                  rd_bit_q     <= sample_q;
                  rd_bit_vld_q <= 1'b1;
                  arb_lost_q   <= (cmd_q == CMD_WB1) && !sample_q;
                end
              end else begin
                phase_q            <= 2'(phase_q + 2'd1);
                {scl_t_q, sda_t_q} <= next_lines_d;
              end
            end
          end
        end

        DONE: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scl_o      = 1'b0;
  assign bus.sda_o      = 1'b0;
  assign bus.scl_t      = scl_t_q;
  assign bus.sda_t      = sda_t_q;
  assign bus.rd_bit     = rd_bit_q;
  assign bus.rd_bit_vld = rd_bit_vld_q;
  assign bus.arb_lost   = arb_lost_q;
  assign bus.busy       = busy_q;
  assign bus.cmd_ready  = cmd_ready_q;

endmodule

// File: tb/tb_i2c_bit_tap.sv
// ---------------------------------------------------------------------------
// tb_i2c_bit_tap
// Directed tests for i2c_bit_tap with PERSCALER=4. Stimulus pushes expected
// line/status values per cycle and expected bit results into queues; a
// negedge monitor pops and compares them as the DUT presents its outputs.
// ---------------------------------------------------------------------------
module tb_i2c_bit_tap;

  localparam int unsigned P = 4;

  localparam int S_SCL_T  = 0;
  localparam int S_SDA_T  = 1;
  localparam int S_RDY    = 2;
  localparam int S_BUSY   = 3;
  localparam int S_VLD    = 4;
  localparam int S_RDBIT  = 5;
  localparam int S_ARB    = 6;
  localparam int S_SCL_O  = 7;
  localparam int S_SDA_O  = 8;

  typedef struct packed {
    int   cyc;
    int   sig;
    logic val;
    int   tid;
  } probe_t;

  typedef struct packed {
    int   cyc;
    logic rd;
    logic arb;
    int   tid;
  } rd_exp_t;

  logic clock    = 1'b0;
  logic rst      = 1'b1;
  logic scl_hold = 1'b0;
  logic sda_pull = 1'b0;
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  probe_t  probe_q[$];
  rd_exp_t rd_q[$];

  i2c_bit_tap_if tap_if ();

  i2c_bit_tap #(.PERSCALER(P)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (tap_if)
  );

  // Wired-AND bus: a slave may hold SCL or SDA low on top of the DUT.
  assign tap_if.scl_i = tap_if.scl_t & ~scl_hold;
  assign tap_if.sda_i = tap_if.sda_t & ~sda_pull;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic string sig_name(int s);
    case (s)
      S_SCL_T: return "scl_t";
      S_SDA_T: return "sda_t";
      S_RDY:   return "cmd_ready";
      S_BUSY:  return "busy";
      S_VLD:   return "rd_bit_vld";
      S_RDBIT: return "rd_bit";
      S_ARB:   return "arb_lost";
      S_SCL_O: return "scl_o";
      default: return "sda_o";
    endcase
  endfunction

  function automatic logic sig_val(int s);
    case (s)
      S_SCL_T: return tap_if.scl_t;
      S_SDA_T: return tap_if.sda_t;
      S_RDY:   return tap_if.cmd_ready;
      S_BUSY:  return tap_if.busy;
      S_VLD:   return tap_if.rd_bit_vld;
      S_RDBIT: return tap_if.rd_bit;
      S_ARB:   return tap_if.arb_lost;
      S_SCL_O: return tap_if.scl_o;
      default: return tap_if.sda_o;
    endcase
  endfunction

  task automatic check_bit(int tid, string what, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL t%0d %s at cyc %0d: got %b want %b", tid, what, cyc, act, exp);
    end
  endtask

  task automatic check_int(int tid, string what, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL t%0d %s: got %0d want %0d", tid, what, act, exp);
    end
  endtask

  // Insert keeping the probe queue ordered by cycle.
  task automatic push(int c, int s, logic v, int tid);
    probe_t p;
    int     i;
    p.cyc = c;
    p.sig = s;
    p.val = v;
    p.tid = tid;
    i = probe_q.size();
    while (i > 0 && probe_q[i-1].cyc > c) i--;
    probe_q.insert(i, p);
  endtask

  task automatic push_rd(int c, logic rd, logic arb, int tid);
    rd_exp_t r;
    r.cyc = c;
    r.rd  = rd;
    r.arb = arb;
    r.tid = tid;
    rd_q.push_back(r);
  endtask

  // Returns at a falling edge with cyc >= n.
  task automatic wait_cyc(int n);
    do @(negedge clock); while (cyc < n);
  endtask

  // Called at a falling edge; returns the acceptance cycle.
  task automatic issue(input logic [2:0] c, input int tid, output int a);
    int k = 0;
    while (tap_if.cmd_ready !== 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (k >= 100) check_bit(tid, "issue_wait_cmd_ready", tap_if.cmd_ready, 1'b1);
    tap_if.cmd     = c;
    tap_if.cmd_vld = 1'b1;
    a = cyc;
    @(posedge clock);
    #1;
    tap_if.cmd_vld = 1'b0;
  endtask

  // Monitor: per-cycle probes, then bit-result events on rd_bit_vld.
  always @(negedge clock) begin : monitor
    probe_t  p;
    rd_exp_t r;
    while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
      p = probe_q.pop_front();
      if (p.cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL t%0d probe %s cyc %0d skipped (now %0d)", p.tid, sig_name(p.sig), p.cyc, cyc);
      end else begin
        check_bit(p.tid, sig_name(p.sig), sig_val(p.sig), p.val);
      end
    end
    if (tap_if.rd_bit_vld === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected rd_bit_vld at cyc %0d: got 1 want 0", cyc);
      end else begin
        r = rd_q.pop_front();
        check_int(r.tid, "done_cycle", cyc, r.cyc);
        check_bit(r.tid, "rd_bit@vld", tap_if.rd_bit, r.rd);
        check_bit(r.tid, "arb_lost@vld", tap_if.arb_lost, r.arb);
      end
    end else if (tap_if.arb_lost !== 1'b0 && cyc > 1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected arb_lost at cyc %0d: got %b want 0", cyc, tap_if.arb_lost);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a;
    tap_if.cmd_vld = 1'b0;
    tap_if.cmd     = 3'd0;

    // t0: reset values, then cmd_ready on first cycle out of reset
    push(2, S_SCL_T, 1'b1, 0);
    push(2, S_SDA_T, 1'b1, 0);
    push(2, S_RDY,   1'b0, 0);
    push(2, S_BUSY,  1'b0, 0);
    push(2, S_VLD,   1'b0, 0);
    push(2, S_RDBIT, 1'b0, 0);
    push(2, S_ARB,   1'b0, 0);
    push(2, S_SCL_O, 1'b0, 0);
    push(2, S_SDA_O, 1'b0, 0);
    push(4, S_RDY,   1'b0, 0);
    push(5, S_RDY,   1'b1, 0);
    push(5, S_BUSY,  1'b0, 0);
    tap_if.cmd_vld = 1'b1;
    tap_if.cmd     = 3'd4;
    wait_cyc(4);
    tap_if.cmd_vld = 1'b0;
    rst = 1'b0;

    // t1: START accepted at cycle 10
    wait_cyc(10);
    issue(3'd1, 1, a);
    check_int(1, "start_accept_cycle", a, 10);
    push(a+1,  S_SCL_T, 1'b1, 1);
    push(a+1,  S_SDA_T, 1'b1, 1);
    push(a+1,  S_BUSY,  1'b1, 1);
    push(a+1,  S_RDY,   1'b0, 1);
    push(a+8,  S_SDA_T, 1'b1, 1);
    push(a+9,  S_SDA_T, 1'b0, 1);
    push(a+16, S_SDA_T, 1'b0, 1);
    push(a+12, S_SCL_T, 1'b1, 1);
    push(a+13, S_SCL_T, 1'b0, 1);
    push(a+16, S_SCL_T, 1'b0, 1);
    push(a+17, S_BUSY,  1'b1, 1);
    push(a+17, S_RDY,   1'b0, 1);
    push(a+17, S_VLD,   1'b0, 1);
    push(a+18, S_RDY,   1'b1, 1);
    push(a+18, S_BUSY,  1'b0, 1);
    push(a+20, S_SCL_T, 1'b0, 1);
    push(a+20, S_SDA_T, 1'b0, 1);

    // t2: RBIT, SDA released by everyone -> reads 1
    wait_cyc(a+20);
    issue(3'd5, 2, a);
    push(a+1,  S_SCL_T, 1'b0, 2);
    push(a+1,  S_SDA_T, 1'b1, 2);
    push(a+4,  S_SCL_T, 1'b0, 2);
    push(a+5,  S_SCL_T, 1'b1, 2);
    push(a+12, S_SCL_T, 1'b1, 2);
    push(a+13, S_SCL_T, 1'b0, 2);
    push(a+16, S_VLD,   1'b0, 2);
    push(a+18, S_VLD,   1'b0, 2);
    push(a+18, S_RDY,   1'b1, 2);
    push_rd(a+17, 1'b1, 1'b0, 2);

    // t3: WBIT1 while another master pulls SDA low -> arbitration lost
    wait_cyc(a+20);
    sda_pull = 1'b1;
    issue(3'd4, 3, a);
    push(a+9,  S_SDA_T, 1'b1, 3);
    push(a+16, S_ARB,   1'b0, 3);
    push(a+17, S_RDY,   1'b0, 3);
    push(a+18, S_ARB,   1'b0, 3);
    push(a+18, S_RDY,   1'b1, 3);
    push(a+20, S_RDBIT, 1'b0, 3);
    push_rd(a+17, 1'b0, 1'b1, 3);
    wait_cyc(a+18);
    sda_pull = 1'b0;

    // t4: WBIT0 with SCL stretched for 10 cycles from the start of P1
    wait_cyc(a+20);
    issue(3'd3, 4, a);
    push(a+1,  S_SDA_T, 1'b0, 4);
    push(a+4,  S_SCL_T, 1'b0, 4);
    push(a+5,  S_SCL_T, 1'b1, 4);
    push(a+14, S_SCL_T, 1'b1, 4);
    push(a+18, S_SCL_T, 1'b1, 4);
    push(a+20, S_SDA_T, 1'b0, 4);
    push(a+22, S_SCL_T, 1'b1, 4);
    push(a+23, S_SCL_T, 1'b0, 4);
    push(a+26, S_BUSY,  1'b1, 4);
    push(a+26, S_VLD,   1'b0, 4);
    push(a+27, S_RDY,   1'b0, 4);
    push(a+28, S_RDY,   1'b1, 4);
    push_rd(a+27, 1'b0, 1'b0, 4);
    wait_cyc(a+5);
    scl_hold = 1'b1;
    wait_cyc(a+15);
    scl_hold = 1'b0;

    // t5: STOP aborted by reset at A+6
    wait_cyc(a+30);
    issue(3'd2, 5, a);
    push(a+1,  S_SCL_T, 1'b0, 5);
    push(a+1,  S_SDA_T, 1'b0, 5);
    push(a+5,  S_SCL_T, 1'b1, 5);
    push(a+6,  S_SDA_T, 1'b0, 5);
    push(a+7,  S_SCL_T, 1'b1, 5);
    push(a+7,  S_SDA_T, 1'b1, 5);
    push(a+7,  S_RDY,   1'b0, 5);
    push(a+7,  S_BUSY,  1'b0, 5);
    push(a+7,  S_VLD,   1'b0, 5);
    push(a+8,  S_RDY,   1'b1, 5);
    push(a+8,  S_BUSY,  1'b0, 5);
    push(a+8,  S_VLD,   1'b0, 5);
    push(a+8,  S_RDBIT, 1'b0, 5);
    push(a+10, S_SDA_T, 1'b1, 5);
    push(a+10, S_VLD,   1'b0, 5);
    wait_cyc(a+6);
    rst = 1'b1;
    wait_cyc(a+7);
    rst = 1'b0;

    // t6: reserved command is a zero-length pass through DONE
    wait_cyc(a+12);
    issue(3'd7, 6, a);
    push(a+1, S_BUSY,  1'b1, 6);
    push(a+1, S_RDY,   1'b0, 6);
    push(a+1, S_SCL_T, 1'b1, 6);
    push(a+1, S_SDA_T, 1'b1, 6);
    push(a+1, S_VLD,   1'b0, 6);
    push(a+1, S_ARB,   1'b0, 6);
    push(a+2, S_BUSY,  1'b0, 6);
    push(a+2, S_RDY,   1'b1, 6);
    push(a+2, S_SCL_T, 1'b1, 6);
    push(a+2, S_SDA_T, 1'b1, 6);

    // t7: NOP behaves the same way
    wait_cyc(a+4);
    issue(3'd0, 7, a);
    push(a+1, S_BUSY,  1'b1, 7);
    push(a+1, S_RDY,   1'b0, 7);
    push(a+1, S_SDA_T, 1'b1, 7);
    push(a+2, S_BUSY,  1'b0, 7);
    push(a+2, S_RDY,   1'b1, 7);
    push(a+2, S_SCL_T, 1'b1, 7);

    // t8: RSTART, with a STOP offered mid-command that must be ignored
    wait_cyc(a+4);
    issue(3'd6, 8, a);
    push(a+1,  S_SCL_T, 1'b0, 8);
    push(a+1,  S_SDA_T, 1'b1, 8);
    push(a+5,  S_SCL_T, 1'b1, 8);
    push(a+5,  S_SDA_T, 1'b1, 8);
    push(a+9,  S_SCL_T, 1'b1, 8);
    push(a+9,  S_SDA_T, 1'b0, 8);
    push(a+13, S_SCL_T, 1'b0, 8);
    push(a+13, S_SDA_T, 1'b0, 8);
    push(a+16, S_SCL_T, 1'b0, 8);
    push(a+17, S_BUSY,  1'b1, 8);
    push(a+17, S_VLD,   1'b0, 8);
    push(a+18, S_RDY,   1'b1, 8);
    push(a+18, S_BUSY,  1'b0, 8);
    push(a+19, S_BUSY,  1'b0, 8);
    push(a+19, S_SCL_T, 1'b0, 8);
    push(a+19, S_SDA_T, 1'b0, 8);
    wait_cyc(a+3);
    tap_if.cmd     = 3'd2;
    tap_if.cmd_vld = 1'b1;
    wait_cyc(a+4);
    tap_if.cmd_vld = 1'b0;

    wait_cyc(a+25);
    check_int(99, "probes_left", probe_q.size(), 0);
    check_int(99, "rd_events_left", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
